// File: rtl/jelly2_video_overlay_bram_memory.sv
// Double-buffered overlay image store: an AXI4-Stream frame writer fills one bank
// while the overlay core reads the other; banks swap only at a read-side frame start.
module jelly2_video_overlay_bram_memory #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDATA_WIDTH = 24,
  parameter int IMG_X_WIDTH = 12,
  parameter int IMG_Y_WIDTH = 12,
  parameter int MEM_X_WIDTH = 8,
  parameter int MEM_Y_WIDTH = 7,
  parameter     RAM_TYPE    = "block"
) (
  input  logic                   aresetn,
  input  logic                   aclk,
  input  logic [IMG_Y_WIDTH-1:0] param_height,
  input  logic                   rd_swap,
  input  logic                   mem_en,
  input  logic [MEM_X_WIDTH-1:0] mem_addrx,
  input  logic [MEM_Y_WIDTH-1:0] mem_addry,
  output logic [TDATA_WIDTH-1:0] mem_dout,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic                   status_rd_bank,
  output logic                   status_pending,
  output logic [15:0]            status_frame_count,
  output logic                   status_sof_error
);

  localparam int ADDR_W = 1 + MEM_Y_WIDTH + MEM_X_WIDTH;

  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [IMG_X_WIDTH-1:0] x_q, x_d;
  logic [IMG_Y_WIDTH-1:0] y_q, y_d;
  logic [IMG_Y_WIDTH-1:0] h_q, h_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   pending_q, pending_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   sof_err_q, sof_err_d;
  logic                   tready_q;
  logic [TDATA_WIDTH-1:0] dout_q;

  logic                   beat, sof, swap, accept, complete, in_bounds, we, wr_bank;
  logic [IMG_X_WIDTH-1:0] cur_x;
  logic [IMG_Y_WIDTH-1:0] cur_y, eff_h, h_m1;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;

  (* ram_style = RAM_TYPE *)
  logic [TDATA_WIDTH-1:0] mem_ram [0:(1<<ADDR_W)-1];

  // An SOF beat is pixel (0,0) of a fresh frame regardless of where the counters are.
  always_comb begin
    beat      = s_axi4s_tvalid & tready_q;
    sof       = beat & s_axi4s_tuser[0];
    swap      = rd_swap & pending_q;
    accept    = beat & (sof | (state_q == ST_WRITE));
    cur_x     = sof ? '0 : x_q;
    cur_y     = sof ? '0 : y_q;
    eff_h     = sof ? param_height : h_q;
    h_m1      = (eff_h == '0) ? '0 : eff_h - IMG_Y_WIDTH'(1);
    complete  = accept & s_axi4s_tlast & (cur_y == h_m1);
    in_bounds = ((cur_x >> MEM_X_WIDTH) == '0) && ((cur_y >> MEM_Y_WIDTH) == '0);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      h_q         <= '0;
      rd_bank_q   <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      sof_err_q   <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      h_q         <= h_d;
      rd_bank_q   <= rd_bank_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      sof_err_q   <= sof_err_d;
      tready_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    h_d     = h_q;
    if (accept) begin
      h_d = eff_h;
      if (s_axi4s_tlast) begin
        x_d = '0;
        y_d = (&cur_y) ? cur_y : cur_y + IMG_Y_WIDTH'(1);
      end else begin
        x_d = (&cur_x) ? cur_x : cur_x + IMG_X_WIDTH'(1);
        y_d = cur_y;
      end
      state_d = complete ? ST_IDLE : ST_WRITE;
    end
  end

  // Completion outranks a same-cycle swap so a just-finished frame is never lost.
  always_comb begin
    wr_bank     = swap ? rd_bank_q : ~rd_bank_q;
    we          = aresetn & accept & in_bounds;
    rd_bank_d   = swap ? ~rd_bank_q : rd_bank_q;
    pending_d   = pending_q;
    if (complete)        pending_d = 1'b1;
    else if (swap | sof) pending_d = 1'b0;
    frame_cnt_d = complete ? frame_cnt_q + 16'd1 : frame_cnt_q;
    sof_err_d   = sof_err_q | (sof & (state_q == ST_WRITE));
  end

  assign wr_addr = {wr_bank, cur_y[MEM_Y_WIDTH-1:0], cur_x[MEM_X_WIDTH-1:0]};
  assign rd_addr = {rd_bank_q, mem_addry, mem_addrx};

  always_ff @(posedge aclk) begin
    if (we) mem_ram[wr_addr] <= s_axi4s_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)    dout_q <= '0;
    else if (mem_en) dout_q <= mem_ram[rd_addr];
  end

  assign mem_dout           = dout_q;
  assign s_axi4s_tready     = tready_q;
  assign status_rd_bank     = rd_bank_q;
  assign status_pending     = pending_q;
  assign status_frame_count = frame_cnt_q;
  assign status_sof_error   = sof_err_q;

endmodule

// File: tb/tb_jelly2_video_overlay_bram_memory.sv
// Bench for the double-buffered overlay store: directed table, corner-case sequences
// and randomized traffic against a frame-level reference model.
module tb_jelly2_video_overlay_bram_memory;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  param_height;
  logic        rd_swap, mem_en;
  logic [1:0]  mem_addrx, mem_addry;
  logic [23:0] mem_dout;
  logic [0:0]  s_tuser;
  logic        s_tlast, s_tvalid, s_tready;
  logic [23:0] s_tdata;
  logic        st_rdb, st_pend, st_err;
  logic [15:0] st_cnt;

  jelly2_video_overlay_bram_memory #(
    .TUSER_WIDTH(1), .TDATA_WIDTH(24), .IMG_X_WIDTH(4), .IMG_Y_WIDTH(4),
    .MEM_X_WIDTH(2), .MEM_Y_WIDTH(2), .RAM_TYPE("block")
  ) dut (
    .aresetn(aresetn), .aclk(aclk), .param_height(param_height), .rd_swap(rd_swap),
    .mem_en(mem_en), .mem_addrx(mem_addrx), .mem_addry(mem_addry), .mem_dout(mem_dout),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .status_rd_bank(st_rdb), .status_pending(st_pend),
    .status_frame_count(st_cnt), .status_sof_error(st_err)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: whole-frame rules with integer counters and a 2x4x4 image array.
  logic [23:0] mram   [0:1][0:3][0:3];
  bit          mvalid [0:1][0:3][0:3];
  bit          m_inframe, m_pend, m_err, m_tready, m_dknown;
  int          m_x, m_y, m_h, m_rdb, m_cnt;
  logic [23:0] m_dout;

  task automatic model_update();
    int          wb;
    bit          beat, sof, swap, complete, rk;
    logic [23:0] rv;
    if (!aresetn) begin
      m_inframe = 0; m_x = 0; m_y = 0; m_h = 0; m_pend = 0; m_rdb = 0;
      m_cnt = 0; m_err = 0; m_tready = 0; m_dout = '0; m_dknown = 1;
      return;
    end
    rv       = mram[m_rdb][mem_addry][mem_addrx];
    rk       = mvalid[m_rdb][mem_addry][mem_addrx];
    beat     = s_tvalid && m_tready;
    sof      = beat && s_tuser[0];
    swap     = rd_swap && m_pend;
    wb       = swap ? m_rdb : 1 - m_rdb;
    complete = 0;
    if (beat && (m_inframe || sof)) begin
      if (sof) begin
        if (m_inframe) m_err = 1;
        m_x = 0; m_y = 0; m_h = int'(param_height); m_inframe = 1;
      end
      if (m_x < 4 && m_y < 4) begin
        mram[wb][m_y][m_x]   = s_tdata;
        mvalid[wb][m_y][m_x] = 1;
        if (mem_en && wb == m_rdb && m_y == int'(mem_addry) && m_x == int'(mem_addrx)) rk = 0;
      end
      if (s_tlast) begin
        if (m_y == ((m_h == 0) ? 0 : m_h - 1)) begin complete = 1; m_inframe = 0; end
        m_x = 0;
        m_y = (m_y < 15) ? m_y + 1 : 15;
      end else begin
        m_x = (m_x < 15) ? m_x + 1 : 15;
      end
    end
    if (complete)          m_pend = 1;
    else if (swap || sof)  m_pend = 0;
    if (swap) m_rdb = 1 - m_rdb;
    if (complete) m_cnt = (m_cnt + 1) % 65536;
    if (mem_en) begin m_dout = rv; m_dknown = rk; end
    m_tready = 1;
  endtask

  task automatic cycle();
    model_update();
    @(posedge aclk);
    #1;
    chk("tready",  32'(s_tready), 32'(m_tready));
    chk("pending", 32'(st_pend),  32'(m_pend));
    chk("rd_bank", 32'(st_rdb),   32'(m_rdb));
    chk("count",   32'(st_cnt),   32'(m_cnt));
    chk("sof_err", 32'(st_err),   32'(m_err));
    if (m_dknown) chk("dout", 32'(mem_dout), 32'(m_dout));
  endtask

  task automatic idle();
    s_tvalid = 0; s_tuser = '0; s_tlast = 0; s_tdata = '0;
    rd_swap = 0; mem_en = 0; mem_addrx = '0; mem_addry = '0;
  endtask

  task automatic send_frame(input int h, input int w, input int base,
                            input bit swap_first, input bit swap_last);
    param_height = 4'(h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        s_tvalid = 1;
        s_tuser  = 1'((x == 0) && (y == 0));
        s_tlast  = (x == w - 1);
        s_tdata  = 24'(base + y * 16 + x);
        rd_swap  = (swap_first && x == 0 && y == 0) || (swap_last && y == h - 1 && x == w - 1);
        cycle();
      end
    idle();
  endtask

  task automatic rd(input int ax, input int ay, input int exp, input string nm);
    mem_en = 1; mem_addrx = 2'(ax); mem_addry = 2'(ay);
    cycle();
    chk(nm, 32'(mem_dout), 32'(exp));
    mem_en = 0;
  endtask

  task automatic do_swap();
    rd_swap = 1; cycle(); rd_swap = 0;
  endtask

  typedef struct {
    bit sof, last, valid, swap, en;
    logic [23:0] data;
    logic [1:0]  ax, ay;
    bit          e_pend, e_rdb, chk_dout;
    logic [15:0] e_cnt;
    logic [23:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit sof, bit last, bit valid, bit swap, bit en, int data,
                              int ax, int ay, bit e_pend, bit e_rdb, int e_cnt,
                              bit chk_dout, int e_dout);
    vec_t v;
    v.sof = sof; v.last = last; v.valid = valid; v.swap = swap; v.en = en;
    v.data = 24'(data); v.ax = 2'(ax); v.ay = 2'(ay);
    v.e_pend = e_pend; v.e_rdb = e_rdb; v.e_cnt = 16'(e_cnt);
    v.chk_dout = chk_dout; v.e_dout = 24'(e_dout);
    return v;
  endfunction

  int saved_rdb, pos, len;

  initial begin
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(i == 0, (i % 4) == 3, 1, 0, 0, (i / 4) * 16 + (i % 4), 0, 0,
                       i == 15, 0, (i == 15) ? 1 : 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 3, 0, 1, 1, 1, 'h32));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h32));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 'h32));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 'h32));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 2, 0, 1, 1, 1, 'h21));

    idle();
    param_height = 4'd4;
    aresetn = 0;
    repeat (3) cycle();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_dout",   32'(mem_dout), 32'd0);
    aresetn = 1;
    cycle();
    chk("tready_after_rst", 32'(s_tready), 32'd1);

    foreach (tbl[i]) begin
      s_tvalid = tbl[i].valid; s_tuser = tbl[i].sof; s_tlast = tbl[i].last;
      s_tdata = tbl[i].data; rd_swap = tbl[i].swap; mem_en = tbl[i].en;
      mem_addrx = tbl[i].ax; mem_addry = tbl[i].ay;
      cycle();
      chk("tbl_pend", 32'(st_pend), 32'(tbl[i].e_pend));
      chk("tbl_rdb",  32'(st_rdb),  32'(tbl[i].e_rdb));
      chk("tbl_cnt",  32'(st_cnt),  32'(tbl[i].e_cnt));
      if (tbl[i].chk_dout) chk("tbl_dout", 32'(mem_dout), 32'(tbl[i].e_dout));
    end
    idle();

    // 20-pixel lines: x must saturate at 15 instead of wrapping back onto x=0..3
    send_frame(2, 20, 'h100, 0, 0);
    cycle();
    chk("clip_pend", 32'(st_pend), 32'd1);
    do_swap();
    rd(0, 0, 'h100, "clip_x0");
    rd(3, 0, 'h103, "clip_x3");
    rd(0, 1, 'h110, "clip_y1");

    param_height = 4'd4;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1; s_tuser = 1'(i == 0); s_tlast = (i % 4) == 3; s_tdata = 24'hEEE;
      cycle();
    end
    send_frame(4, 4, 'h500, 0, 0);
    chk("midsof_err",  32'(st_err),  32'd1);
    chk("midsof_pend", 32'(st_pend), 32'd1);
    chk("midsof_cnt",  32'(st_cnt),  32'd3);
    do_swap();
    rd(1, 0, 'h501, "midsof_data");

    send_frame(4, 4, 'hA00, 0, 0);
    chk("ovw_a_pend", 32'(st_pend), 32'd1);
    send_frame(4, 4, 'hB00, 0, 0);
    chk("ovw_b_pend", 32'(st_pend), 32'd1);
    do_swap();
    rd(2, 1, 'hB12, "ovw_b_visible");

    saved_rdb = m_rdb;
    send_frame(4, 4, 'hC00, 0, 1);
    chk("same_cyc_pend", 32'(st_pend), 32'd1);
    chk("same_cyc_rdb",  32'(st_rdb),  32'(saved_rdb));
    send_frame(4, 4, 'hD00, 1, 0);
    rd(0, 0, 'hC00, "sofswap_old");
    do_swap();
    rd(0, 0, 'hD00, "sofswap_new");

    param_height = 4'd4;
    for (int i = 0; i < 6; i++) begin
      s_tvalid = 1; s_tuser = 1'(i == 0); s_tlast = (i == 3); s_tdata = 24'(i);
      cycle();
    end
    aresetn = 0;
    repeat (2) cycle();
    chk("rstmid_tready", 32'(s_tready), 32'd0);
    chk("rstmid_pend",   32'(st_pend),  32'd0);
    chk("rstmid_cnt",    32'(st_cnt),   32'd0);
    chk("rstmid_err",    32'(st_err),   32'd0);
    chk("rstmid_rdb",    32'(st_rdb),   32'd0);
    aresetn = 1; idle();
    cycle();
    chk("rstmid_tready_up", 32'(s_tready), 32'd1);

    pos = 0; len = 4;
    for (int c = 0; c < 3000; c++) begin
      aresetn   = ($urandom_range(0, 499) != 0);
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tuser   = 1'(s_tvalid && ((pos == 0 && $urandom_range(0, 4) == 0) || $urandom_range(0, 59) == 0));
      if (s_tuser[0]) param_height = 4'($urandom_range(0, 5));
      s_tlast   = (pos == len - 1);
      s_tdata   = 24'($urandom);
      rd_swap   = ($urandom_range(0, 11) == 0);
      mem_en    = 1'($urandom_range(0, 1));
      mem_addrx = 2'($urandom_range(0, 3));
      mem_addry = 2'($urandom_range(0, 3));
      cycle();
      if (s_tvalid) begin
        if (s_tlast) begin pos = 0; len = $urandom_range(1, 6); end
        else pos++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
